button_press_counter: RTL
=========================

// Module: button_press_counter
// PURPOSE
//  Consumes the debounced button level from the debounce stage and turns it into events.
//  - Emits a one-cycle press pulse on each press.
//  - Counts presses for LED display.
//  - Flags long presses; optionally auto-repeats while the button is held.
//  Sits directly downstream of the button debounce stage; count drives board LEDs.
// PARAMETERS
//  COUNT_WIDTH   8              width of press counter / LED bus
//  HOLD_WIDTH    24             width of hold-time counter
//  LONG_TOTAL    24'd6000000    cycles held after press before long_press (0.5 s @ 12 MHz)
//  REPEAT_TOTAL  24'd1200000    auto-repeat period in cycles (100 ms @ 12 MHz)
// PORTS
//  clk         in   1            system clock, all logic on posedge
//  rst         in   1            synchronous reset, active-high
//  butd        in   1            debounced button level, synchronous to clk
//  press       out  1            one-cycle pulse per press (and per auto-repeat)
//  long_press  out  1            one-cycle pulse when hold reaches LONG_TOTAL
//  count       out  COUNT_WIDTH  number of press pulses issued, wraps
// BEHAVIOUR
//  Reset (rst=1 on a clk edge):
//   - state=IDLE; press=0; long_press=0; count=0; hold_count=0.
//   - butd_q=1, so a button held through reset release is not counted; it must be released first.
//  Edge detect:
//   - butd_q <= butd every cycle.
//   - rise = butd & ~butd_q.
//  press and long_press are registered, default 0 each cycle, never high together.
//  States:
//   IDLE:
//    - on rise: press<=1, count<=count+1, hold_count<=0, ->HELD.
//   HELD:
//    - butd=0: ->IDLE (release has priority over every other condition).
//    - else if hold_count==LONG_TOTAL-1: long_press<=1, hold_count<=0, ->LONG.
//    - else hold_count<=hold_count+1.
//   LONG:
//    - butd=0: ->IDLE.
//    - else: see CONFIGURATION.
//  Latency:
//   - press is high in the cycle after the first edge sampling butd=1 with butd_q=0.
//   - long_press is high exactly LONG_TOTAL cycles after press.
//  count wraps 2^COUNT_WIDTH-1 -> 0 silently; no saturation, no flag.
//  Release on the same edge hold_count hits LONG_TOTAL-1: no long_press; go to IDLE.
//  Illegal state encoding: ->IDLE, outputs 0.
//  rst asserted mid-hold: reset values apply on that edge; no pulse is emitted.
//  LONG_TOTAL and REPEAT_TOTAL must be >=2 and fit in HOLD_WIDTH bits.
// CONFIGURATION
//  BUTTON_AUTO_REPEAT_EN defined:
//   - In LONG with butd=1, hold_count increments.
//   - At hold_count==REPEAT_TOTAL-1: press<=1, count<=count+1, hold_count<=0.
//   - First repeat press is REPEAT_TOTAL cycles after long_press, then every REPEAT_TOTAL cycles.
//  BUTTON_AUTO_REPEAT_EN undefined:
//   - LONG holds with no counting and no pulses until release.
//   - REPEAT_TOTAL is unused.
// TESTING (bench params: COUNT_WIDTH=4, LONG_TOTAL=10, REPEAT_TOTAL=4)
//  1. Reset, butd 0->1 for 3 cycles -> press high 1 cycle, count=1, no long_press.
//  2. Hold butd=1 for 30 cycles -> long_press once, 10 cycles after press.
//     - macro on: press at +4,+8,... after long_press; count increments each.
//     - macro off: count stays 1.
//  3. Release on the cycle hold_count==9 -> no long_press, state IDLE, next rise counts normally.
//  4. 16 short presses from reset -> count 1..15 then 0, press pulses=16.
//  5. butd=1 held through rst deassert -> no press until butd 0 then 1; then count=1.
//  6. rst pulsed mid-HELD (hold_count=5) -> all outputs 0 next cycle; butd still 1 gives no press.

Source files
------------

// File: rtl/button_press_counter_if.sv
// Button event bus between the debounce stage side and button_press_counter.
//   butd        debounced button level, synchronous to clk
//   press       one-cycle pulse per press / auto-repeat
//   long_press  one-cycle pulse when the hold reaches the long-press time
//   count       number of press pulses issued, wraps
// master: drives butd, observes events. slave: the counter itself.
interface button_press_counter_if #(
  parameter int unsigned COUNT_WIDTH = 8
);
  logic                   butd;
  logic                   press;
  logic                   long_press;
  logic [COUNT_WIDTH-1:0] count;

  modport master (output butd, input press, input long_press, input count);
  modport slave  (input butd, output press, output long_press, output count);
endinterface

// File: rtl/button_press_counter.sv
// button_press_counter
//   Turns the debounced button level into events: a one-cycle press pulse per
//   press, a wrapping press count for the LEDs, and a one-cycle long_press pulse
//   once the button has been held LONG_TOTAL cycles after the press.
//   Define BUTTON_AUTO_REPEAT_EN to emit a further press (and count) every
//   REPEAT_TOTAL cycles while the button stays held after long_press.
// Ports:
//   clk   in  system clock, posedge
//   rst   in  synchronous reset, active-high
//   btn   slave modport of button_press_counter_if (butd in; press, long_press,
//         count out)
module button_press_counter #(
  parameter int unsigned           COUNT_WIDTH  = 8,
  parameter int unsigned           HOLD_WIDTH   = 24,
  parameter logic [HOLD_WIDTH-1:0] LONG_TOTAL   = 24'd6000000,
  parameter logic [HOLD_WIDTH-1:0] REPEAT_TOTAL = 24'd1200000
) (
  input  logic                  clk,
  input  logic                  rst,
  button_press_counter_if.slave btn
);

  if (LONG_TOTAL < 2 || REPEAT_TOTAL < 2) begin : g_param_check
    $error("button_press_counter: LONG_TOTAL and REPEAT_TOTAL must be >= 2");
  end

  localparam logic [HOLD_WIDTH-1:0] LONG_LAST = LONG_TOTAL - 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [HOLD_WIDTH-1:0] REPEAT_LAST = REPEAT_TOTAL - 1'b1;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_t;

  state_t                 state, state_nx;
  logic                   butd_q;
  logic                   rise;
  logic                   press_q, press_nx;
  logic                   long_q, long_nx;
  logic [COUNT_WIDTH-1:0] count_q, count_nx;
  logic [HOLD_WIDTH-1:0]  hold_q, hold_nx;

  assign rise = btn.butd & ~butd_q;

  // butd_q resets high so a button held through reset must be released
  // before it can produce a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      butd_q  <= 1'b1;
      press_q <= 1'b0;
      long_q  <= 1'b0;
      count_q <= '0;
      hold_q  <= '0;
    end else begin
      state   <= state_nx;
      butd_q  <= btn.butd;
      press_q <= press_nx;
      long_q  <= long_nx;
      count_q <= count_nx;
      hold_q  <= hold_nx;
    end
  end

  always_comb begin
    state_nx = state;
    press_nx = 1'b0;
    long_nx  = 1'b0;
    count_nx = count_q;
    hold_nx  = hold_q;
    case (state)
      IDLE: begin
        if (rise) begin
          press_nx = 1'b1;
          count_nx = count_q + 1'b1;
          hold_nx  = '0;
          state_nx = HELD;
        end
      end
      HELD: begin
        // Release wins even on the edge the hold time would be reached.
        if (!btn.butd) begin
          state_nx = IDLE;
        end else if (hold_q == LONG_LAST) begin
          long_nx  = 1'b1;
          hold_nx  = '0;
          state_nx = LONG;
        end else begin
          hold_nx = hold_q + 1'b1;
        end
      end
      LONG: begin
        if (!btn.butd) begin
          state_nx = IDLE;
        end else begin
`ifdef BUTTON_AUTO_REPEAT_EN
          if (hold_q == REPEAT_LAST) begin
            press_nx = 1'b1;
            count_nx = count_q + 1'b1;
            hold_nx  = '0;
          end else begin
            hold_nx = hold_q + 1'b1;
          end
`else
          state_nx = LONG;
`endif
        end
      end
      default: begin
        state_nx = IDLE;
        hold_nx  = '0;
      end
    endcase
  end

  assign btn.press      = press_q;
  assign btn.long_press = long_q;
  assign btn.count      = count_q;

endmodule
